// File: rtl/ir_tx_pkg.sv
// ---------------------------------------------------------------------------
// ir_tx_pkg
// Shared definitions for the NEC-style IR transmitter:
//   - tx_state_e   : transmitter FSM states
//   - NEC_*        : default NEC timing constants (12 MHz clock, 13.17 us tick)
//   - SEG_W        : width of the segment (tick) counter
//   - is_mark()    : 1 for the states that drive the carrier envelope
// ---------------------------------------------------------------------------
package ir_tx_pkg;

  localparam int unsigned SEG_W = 16;

  localparam int unsigned NEC_DATA_W   = 32;
  localparam int unsigned NEC_DIV      = 158;
  localparam int unsigned NEC_LEAD_ON  = 684;
  localparam int unsigned NEC_LEAD_OFF = 342;
  localparam int unsigned NEC_RPT_OFF  = 171;
  localparam int unsigned NEC_BIT_ON   = 43;
  localparam int unsigned NEC_ZERO_OFF = 43;
  localparam int unsigned NEC_ONE_OFF  = 128;
  localparam int unsigned NEC_GAP      = 3000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEAD_ON  = 3'd1,
    ST_LEAD_OFF = 3'd2,
    ST_BIT_ON   = 3'd3,
    ST_BIT_OFF  = 3'd4,
    ST_STOP     = 3'd5,
    ST_GAP      = 3'd6
  } tx_state_e;

  // Envelope is high only while a mark is being sent.
  function automatic logic is_mark(input tx_state_e s);
    case (s)
      ST_LEAD_ON, ST_BIT_ON, ST_STOP: is_mark = 1'b1;
      default:                        is_mark = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ir_tick_div.sv
// ---------------------------------------------------------------------------
// ir_tick_div
// Prescaler producing one tick every DIV clk cycles.
//   clk   in  : system clock
//   rst_n in  : synchronous active-low reset
//   clr   in  : holds the counter at 0
//   tick  out : high on the cycle the counter equals DIV-1
// ---------------------------------------------------------------------------
module ir_tick_div #(
  parameter int unsigned DIV = 158
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  // Free-running 0..DIV-1 counter, restarted by clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (clr || w_last) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ir_nec_tx.sv
// ---------------------------------------------------------------------------
// ir_nec_tx
// NEC-style IR transmitter: leader, data bits, stop mark and gap, followed by
// tx_reps repeats sent either as full frames or as NEC repeat codes.
//   clk      in  : system clock
//   rst_n    in  : synchronous active-low reset
//   tx_valid in  : frame request
//   tx_ready out : high exactly in IDLE
//   tx_data  in  : frame word, captured on accept
//   tx_reps  in  : repeats after the first frame, captured on accept
//   tx_mode  in  : 0 = repeat full frames, 1 = repeat codes
//   abort    in  : return to IDLE without done
//   busy     out : ~tx_ready
//   done     out : one-cycle pulse on normal completion
//   env_out  out : unmodulated envelope (1 during marks)
//   ir_out   out : envelope gated by the carrier phase (to IRTXD)
// ---------------------------------------------------------------------------
module ir_nec_tx
  import ir_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = NEC_DATA_W,
  parameter int unsigned DIV       = NEC_DIV,
  parameter int unsigned LEAD_ON   = NEC_LEAD_ON,
  parameter int unsigned LEAD_OFF  = NEC_LEAD_OFF,
  parameter int unsigned RPT_OFF   = NEC_RPT_OFF,
  parameter int unsigned BIT_ON    = NEC_BIT_ON,
  parameter int unsigned ZERO_OFF  = NEC_ZERO_OFF,
  parameter int unsigned ONE_OFF   = NEC_ONE_OFF,
  parameter int unsigned GAP       = NEC_GAP,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [3:0]        tx_reps,
  input  logic              tx_mode,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              env_out,
  output logic              ir_out
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] FIRST_BIT = (LSB_FIRST != 0) ? BIT_W'(0) : BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = (LSB_FIRST != 0) ? BIT_W'(DATA_W - 1) : BIT_W'(0);

  localparam logic [SEG_W-1:0] L_LEAD_ON  = SEG_W'(LEAD_ON);
  localparam logic [SEG_W-1:0] L_LEAD_OFF = SEG_W'(LEAD_OFF);
  localparam logic [SEG_W-1:0] L_RPT_OFF  = SEG_W'(RPT_OFF);
  localparam logic [SEG_W-1:0] L_BIT_ON   = SEG_W'(BIT_ON);
  localparam logic [SEG_W-1:0] L_ZERO_OFF = SEG_W'(ZERO_OFF);
  localparam logic [SEG_W-1:0] L_ONE_OFF  = SEG_W'(ONE_OFF);
  localparam logic [SEG_W-1:0] L_GAP      = SEG_W'(GAP);

  tx_state_e         r_state, w_state_nxt;
  logic [SEG_W-1:0]  r_seg, w_seg_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [3:0]        r_reps, w_reps_nxt;
  logic              r_mode, w_mode_nxt;
  logic              r_rpt, w_rpt_nxt;
  logic              w_done_nxt;
  logic              r_env, r_ir, r_done, r_ready;

  logic              w_tick;
  logic              w_clr;
  logic [SEG_W-1:0]  w_len;
  logic              w_seg_last;
  logic              w_cur_bit;
  logic              w_mark_nxt;

  // Divider is held in IDLE so the first tick of a frame lands DIV cycles
  // after the accept edge.
  assign w_clr = (r_state == ST_IDLE);

  ir_tick_div #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  assign w_cur_bit  = r_data[r_bit];
  assign w_seg_last = (r_seg == (w_len - SEG_W'(1)));
  assign w_mark_nxt = is_mark(w_state_nxt);

  // Length in ticks of the segment belonging to the current state.
  always_comb begin
    w_len = L_GAP;
    case (r_state)
      ST_LEAD_ON:  w_len = L_LEAD_ON;
      ST_LEAD_OFF: w_len = r_rpt ? L_RPT_OFF : L_LEAD_OFF;
      ST_BIT_ON:   w_len = L_BIT_ON;
      ST_BIT_OFF:  w_len = w_cur_bit ? L_ONE_OFF : L_ZERO_OFF;
      ST_STOP:     w_len = L_BIT_ON;
      ST_GAP:      w_len = L_GAP;
      default:     w_len = L_GAP;
    endcase
  end

  // Next-state logic: accept, abort and segment sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_seg_nxt   = r_seg;
    w_bit_nxt   = r_bit;
    w_data_nxt  = r_data;
    w_reps_nxt  = r_reps;
    w_mode_nxt  = r_mode;
    w_rpt_nxt   = r_rpt;
    w_done_nxt  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_seg_nxt = {SEG_W{1'b0}};
      if (tx_valid) begin
        w_state_nxt = ST_LEAD_ON;
        w_data_nxt  = tx_data;
        w_reps_nxt  = tx_reps;
        w_mode_nxt  = tx_mode;
        w_rpt_nxt   = 1'b0;
        w_bit_nxt   = FIRST_BIT;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else if (abort) begin
      w_state_nxt = ST_IDLE;
      w_seg_nxt   = {SEG_W{1'b0}};
    end else if (w_tick) begin
      if (w_seg_last) begin
        w_seg_nxt = {SEG_W{1'b0}};
        case (r_state)
          ST_LEAD_ON: w_state_nxt = ST_LEAD_OFF;
          ST_LEAD_OFF: begin
            // A repeat code has no data: leader space goes straight to the stop mark.
            if (r_rpt) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_state_nxt = ST_BIT_ON;
              w_bit_nxt   = FIRST_BIT;
            end
          end
          ST_BIT_ON: w_state_nxt = ST_BIT_OFF;
          ST_BIT_OFF: begin
            if (r_bit == LAST_BIT) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_state_nxt = ST_BIT_ON;
              w_bit_nxt   = (LSB_FIRST != 0) ? (r_bit + BIT_W'(1)) : (r_bit - BIT_W'(1));
            end
          end
          ST_STOP: w_state_nxt = ST_GAP;
          ST_GAP: begin
            if (r_reps == 4'd0) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_LEAD_ON;
              w_reps_nxt  = r_reps - 4'd1;
              w_rpt_nxt   = r_mode;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end else begin
        w_seg_nxt = r_seg + SEG_W'(1);
      end
    end else begin
      w_seg_nxt = r_seg;
    end
  end

  // State, datapath and output registers; outputs are derived from the
  // next values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_seg   <= {SEG_W{1'b0}};
      r_bit   <= {BIT_W{1'b0}};
      r_data  <= {DATA_W{1'b0}};
      r_reps  <= 4'd0;
      r_mode  <= 1'b0;
      r_rpt   <= 1'b0;
      r_env   <= 1'b0;
      r_ir    <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_seg   <= w_seg_nxt;
      r_bit   <= w_bit_nxt;
      r_data  <= w_data_nxt;
      r_reps  <= w_reps_nxt;
      r_mode  <= w_mode_nxt;
      r_rpt   <= w_rpt_nxt;
      r_env   <= w_mark_nxt;
      // Carrier phase is segment counter bit 0, so each mark opens with phase 0.
      r_ir    <= w_mark_nxt & w_seg_nxt[0];
      r_done  <= w_done_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  assign tx_ready = r_ready;
  assign busy     = ~r_ready;
  assign done     = r_done;
  assign env_out  = r_env;
  assign ir_out   = r_ir;

endmodule

// File: tb/tb_ir_nec_tx.sv
// ---------------------------------------------------------------------------
// tb_ir_nec_tx
// Self-checking bench for ir_nec_tx. Two instances with identical inputs, one
// MSB-first and one LSB-first, are compared cycle by cycle against a
// reference waveform built from the frame's segment list.
// ---------------------------------------------------------------------------
module tb_ir_nec_tx;

  localparam int DIV  = 2;
  localparam int LON  = 8;
  localparam int LOFF = 4;
  localparam int ROFF = 2;
  localparam int BON  = 2;
  localparam int ZOFF = 2;
  localparam int OOFF = 4;
  localparam int GAPT = 6;
  localparam int DW   = 4;

  // {env0,ir0,env1,ir1, busy0,ready0,done0, busy1,ready1,done1}
  localparam logic [9:0] IDLE_V = 10'b0000_010_010;
  localparam logic [9:0] DONE_V = 10'b0000_011_011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, tx_valid, tx_mode, abort;
  logic [DW-1:0] tx_data;
  logic [3:0]    tx_reps;
  logic          rdy0, busy0, done0, env0, ir0;
  logic          rdy1, busy1, done1, env1, ir1;

  ir_nec_tx #(.DATA_W(DW), .DIV(DIV), .LEAD_ON(LON), .LEAD_OFF(LOFF), .RPT_OFF(ROFF),
              .BIT_ON(BON), .ZERO_OFF(ZOFF), .ONE_OFF(OOFF), .GAP(GAPT), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(rdy0), .tx_data(tx_data),
    .tx_reps(tx_reps), .tx_mode(tx_mode), .abort(abort), .busy(busy0), .done(done0),
    .env_out(env0), .ir_out(ir0));

  ir_nec_tx #(.DATA_W(DW), .DIV(DIV), .LEAD_ON(LON), .LEAD_OFF(LOFF), .RPT_OFF(ROFF),
              .BIT_ON(BON), .ZERO_OFF(ZOFF), .ONE_OFF(OOFF), .GAP(GAPT), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(rdy1), .tx_data(tx_data),
    .tx_reps(tx_reps), .tx_mode(tx_mode), .abort(abort), .busy(busy1), .done(done1),
    .env_out(env1), .ir_out(ir1));

  int n_cmp = 0;
  int n_bad = 0;
  int frame_no = 0;

  // Expected {env, ir} per cycle after accept, one queue per instance.
  logic [1:0] q0[$];
  logic [1:0] q1[$];

  function automatic logic [9:0] obs_vec();
    return {env0, ir0, env1, ir1, busy0, rdy0, done0, busy1, rdy1, done1};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One segment: ticks*DIV cycles; carrier phase flips every DIV cycles.
  task automatic push_seg(input int w, input bit mark, input int ticks);
    for (int c = 0; c < ticks * DIV; c++) begin
      bit ph;
      ph = ((c / DIV) % 2) == 1;
      if (w == 0) q0.push_back({mark, mark & ph});
      else        q1.push_back({mark, mark & ph});
    end
  endtask

  task automatic build(input int w, input bit lsb, input logic [DW-1:0] d,
                       input int reps, input bit mode);
    for (int b = 0; b <= reps; b++) begin
      push_seg(w, 1'b1, LON);
      if (b > 0 && mode) begin
        push_seg(w, 1'b0, ROFF);
      end else begin
        push_seg(w, 1'b0, LOFF);
        for (int k = 0; k < DW; k++) begin
          int idx;
          idx = lsb ? k : (DW - 1 - k);
          push_seg(w, 1'b1, BON);
          push_seg(w, 1'b0, d[idx] ? OOFF : ZOFF);
        end
      end
      push_seg(w, 1'b1, BON);
      push_seg(w, 1'b0, GAPT);
    end
  endtask

  // Called at a negedge with the DUTs idle. Returns at the done cycle, or
  // right after an abort/reset cut at index cut_idx.
  task automatic send(input logic [DW-1:0] d, input int reps, input bit mode,
                      input int cut_idx, input bit cut_rst, input bit chain);
    int len;
    frame_no++;
    chk($sformatf("f%0d ready", frame_no), {8'd0, rdy0, rdy1}, {8'd0, 2'b11});
    tx_valid = 1'b1;
    tx_data  = d;
    tx_reps  = reps[3:0];
    tx_mode  = mode;
    q0.delete();
    q1.delete();
    build(0, 1'b0, d, reps, mode);
    build(1, 1'b1, d, reps, mode);
    len = q0.size();
    @(negedge clk);
    if (!chain) tx_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("f%0d c%0d", frame_no, i), obs_vec(), {q0[i], q1[i], 6'b100_100});
      if (i == cut_idx) begin
        if (cut_rst) begin
          rst_n    = 1'b0;
          tx_valid = 1'b1;
          @(negedge clk);
          chk($sformatf("f%0d rst_a", frame_no), obs_vec(), IDLE_V);
          @(negedge clk);
          chk($sformatf("f%0d rst_b", frame_no), obs_vec(), IDLE_V);
          rst_n = 1'b1;
        end else begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk($sformatf("f%0d abort", frame_no), obs_vec(), IDLE_V);
        end
        return;
      end
      @(negedge clk);
    end
    chk($sformatf("f%0d done", frame_no), obs_vec(), DONE_V);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk(tag, obs_vec(), IDLE_V);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 4'd0;
    tx_reps  = 4'd0;
    tx_mode  = 1'b0;
    abort    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", obs_vec(), IDLE_V);
    rst_n = 1'b1;
    idle_chk("idle");

    // Abort while idle has no effect.
    abort = 1'b1;
    idle_chk("abort_idle");
    abort = 1'b0;

    // Single frame, no repeats.
    send(4'b1010, 0, 1'b0, -1, 1'b0, 1'b0);
    idle_chk("single_after");

    // Repeat codes.
    send(4'b1010, 2, 1'b1, -1, 1'b0, 1'b0);
    idle_chk("rptcode_after");

    // Full-frame repeats.
    send(4'b0001, 1, 1'b0, -1, 1'b0, 1'b0);
    idle_chk("fullrpt_after");

    // Abort during the third data bit, then immediate new frame.
    send(4'b1010, 0, 1'b0, 45, 1'b0, 1'b0);
    send(4'b0110, 0, 1'b0, -1, 1'b0, 1'b0);
    idle_chk("abort_after");

    // Reset mid-LEAD_ON with tx_valid held high.
    send(4'b1100, 0, 1'b0, 5, 1'b1, 1'b0);
    send(4'b0011, 0, 1'b0, -1, 1'b0, 1'b0);
    idle_chk("reset_after");

    // Back-to-back frames with tx_valid held.
    send(4'b1001, 1, 1'b1, -1, 1'b0, 1'b1);
    send(4'b0101, 0, 1'b0, -1, 1'b0, 1'b0);
    idle_chk("b2b_after");

    // Randomized frames.
    for (int k = 0; k < 6; k++) begin
      logic [DW-1:0] rd;
      int            rr;
      bit            rm;
      rd = DW'($urandom_range(0, 15));
      rr = $urandom_range(0, 4);
      rm = 1'($urandom_range(0, 1));
      send(rd, rr, rm, -1, 1'b0, 1'b0);
      idle_chk($sformatf("rand%0d_after", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
